// File: rtl/stack_file_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : stack_file_pkg / stack_file_if
// Purpose  : Opcode encodings and the operation/status bundle of the 16x8 stack.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package stack_file_pkg;
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] ADV_1   = 2'b01;
  localparam logic [1:0] DES_1   = 2'b10;
  localparam logic [1:0] DES_2   = 2'b11;
  localparam int unsigned DEPTH_MAX = 16;
endpackage

interface stack_file_if;
  logic [1:0] op;
  logic [7:0] push_data;
  logic       wr_top;
  logic       clr_err;
  logic [7:0] tos;
  logic [7:0] nos;
  logic [4:0] depth;
  logic       empty;
  logic       full;
  logic       ovf;
  logic       unf;

  modport master (
    output op, push_data, wr_top, clr_err,
    input  tos, nos, depth, empty, full, ovf, unf
  );

  modport slave (
    input  op, push_data, wr_top, clr_err,
    output tos, nos, depth, empty, full, ovf, unf
  );
endinterface
`default_nettype wire

// File: rtl/stack_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : stack_file
// Purpose  : 16-entry x 8-bit hardware stack with TOS/NOS view and sticky errors.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module stack_file
  import stack_file_pkg::*;
(
  input  wire         clk,
  input  wire         reset,
  stack_file_if.slave bus
);

  logic [7:0] r_mem [0:15];
  logic [4:0] r_depth;
  logic       r_ovf;
  logic       r_unf;

  logic       w_empty;
  logic       w_full;
  logic       w_has2;
  logic       w_is_hold;
  logic       w_push;
  logic       w_pop1;
  logic       w_pop2;
  logic       w_wr;
  logic       w_ovf_evt;
  logic       w_unf_evt;
  logic       w_mem_we;
  logic [3:0] w_wr_idx;
  logic [3:0] w_top_idx;
  logic [3:0] w_nos_idx;
  logic [4:0] w_depth_nxt;

  assign w_empty   = (r_depth == 5'd0);
  assign w_full    = r_depth[4];
  assign w_has2    = (r_depth >= 5'd2);
  assign w_is_hold = (bus.op == OP_HOLD);

  // Low nibble arithmetic is exact for every legal depth, including 16.
  assign w_top_idx = r_depth[3:0] - 4'd1;
  assign w_nos_idx = r_depth[3:0] - 4'd2;

  always_comb begin
    w_push    = 1'b0;
    w_pop1    = 1'b0;
    w_pop2    = 1'b0;
    w_wr      = 1'b0;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    case (bus.op)
      ADV_1: begin
        w_push    = !w_full;
        w_ovf_evt = w_full;
      end
      DES_1: begin
        w_pop1    = !w_empty;
        w_unf_evt = w_empty;
      end
      DES_2: begin
        w_pop2    = w_has2;
        w_unf_evt = !w_has2;
      end
      default: begin
        w_wr      = w_is_hold && bus.wr_top && !w_empty;
        w_unf_evt = w_is_hold && bus.wr_top && w_empty;
      end
    endcase
  end

  always_comb begin
    w_depth_nxt = r_depth;
    if (w_push)
      w_depth_nxt = r_depth + 5'd1;
    else if (w_pop1)
      w_depth_nxt = r_depth - 5'd1;
    else if (w_pop2)
      w_depth_nxt = r_depth - 5'd2;
  end

  assign w_mem_we = w_push || w_wr;
  assign w_wr_idx = w_push ? r_depth[3:0] : w_top_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth <= 5'd0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_depth <= w_depth_nxt;
      // A fresh error event outranks a simultaneous clear.
      r_ovf   <= (r_ovf && !bus.clr_err) || w_ovf_evt;
      r_unf   <= (r_unf && !bus.clr_err) || w_unf_evt;
    end
  end

  // Storage carries no reset; a cycle spent in reset must not commit a write.
  always_ff @(posedge clk) begin
    if (w_mem_we && reset)
      r_mem[w_wr_idx] <= bus.push_data;
  end

  assign bus.tos   = w_empty ? 8'h00 : r_mem[w_top_idx];
  assign bus.nos   = w_has2  ? r_mem[w_nos_idx] : 8'h00;
  assign bus.depth = r_depth;
  assign bus.empty = w_empty;
  assign bus.full  = w_full;
  assign bus.ovf   = r_ovf;
  assign bus.unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_stack_file
// Purpose  : Directed self-checking bench for stack_file.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_stack_file;
  import stack_file_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  stack_file_if bus();

  stack_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, act, exp);
    end
  endtask

  // Apply one operation for exactly one rising edge, then sample #1 after it.
  task automatic do_op(input logic [1:0] op, input logic [7:0] data,
                       input logic wr, input logic clr);
    @(negedge clk);
    bus.op        = op;
    bus.push_data = data;
    bus.wr_top    = wr;
    bus.clr_err   = clr;
    @(posedge clk);
    #1;
    bus.op      = OP_HOLD;
    bus.wr_top  = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic push(input logic [7:0] data);
    do_op(ADV_1, data, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.op        = OP_HOLD;
    bus.push_data = 8'h00;
    bus.wr_top    = 1'b0;
    bus.clr_err   = 1'b0;
    reset         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_depth", {3'b0, bus.depth}, 8'd0);
    check("rst_tos",   bus.tos, 8'h00);
    check("rst_nos",   bus.nos, 8'h00);
    check("rst_empty", {7'b0, bus.empty}, 8'd1);
    check("rst_full",  {7'b0, bus.full},  8'd0);
    check("rst_ovf",   {7'b0, bus.ovf},   8'd0);
    check("rst_unf",   {7'b0, bus.unf},   8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Underflow on empty, then DES_2 at depth 1 must not partially pop
    do_op(DES_1, 8'h00, 1'b0, 1'b0);
    check("unf_pop1_depth", {3'b0, bus.depth}, 8'd0);
    check("unf_pop1_flag",  {7'b0, bus.unf},   8'd1);
    do_op(OP_HOLD, 8'h00, 1'b0, 1'b1);
    check("unf_clr", {7'b0, bus.unf}, 8'd0);
    push(8'h05);
    do_op(DES_2, 8'h00, 1'b0, 1'b0);
    check("unf_pop2_depth", {3'b0, bus.depth}, 8'd1);
    check("unf_pop2_tos",   bus.tos, 8'h05);
    check("unf_pop2_flag",  {7'b0, bus.unf}, 8'd1);
    do_op(DES_1, 8'h00, 1'b0, 1'b1);
    check("pop_last_depth", {3'b0, bus.depth}, 8'd0);
    check("pop_last_unf",   {7'b0, bus.unf},   8'd0);

    // New error beats a simultaneous clear
    do_op(DES_1, 8'h00, 1'b0, 1'b1);
    check("clr_vs_err", {7'b0, bus.unf}, 8'd1);
    do_op(OP_HOLD, 8'h00, 1'b0, 1'b1);

    // Basic push / DES_2
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("p3_depth", {3'b0, bus.depth}, 8'd3);
    check("p3_tos",   bus.tos, 8'h33);
    check("p3_nos",   bus.nos, 8'h22);
    check("p3_empty", {7'b0, bus.empty}, 8'd0);
    do_op(DES_2, 8'h00, 1'b0, 1'b0);
    check("d2_depth", {3'b0, bus.depth}, 8'd1);
    check("d2_tos",   bus.tos, 8'h11);
    check("d2_nos",   bus.nos, 8'h00);
    do_op(DES_1, 8'h00, 1'b1, 1'b0);
    check("pop_wrtop_depth", {3'b0, bus.depth}, 8'd0);
    check("pop_wrtop_unf",   {7'b0, bus.unf},   8'd0);

    // Write-top at depth 0 is an underflow with no write
    do_op(OP_HOLD, 8'hEE, 1'b1, 1'b0);
    check("wr0_depth", {3'b0, bus.depth}, 8'd0);
    check("wr0_unf",   {7'b0, bus.unf},   8'd1);
    check("wr0_tos",   bus.tos, 8'h00);
    do_op(OP_HOLD, 8'h00, 1'b0, 1'b1);

    // Write-top, and wr_top ignored during a push
    push(8'h40);
    push(8'h41);
    do_op(OP_HOLD, 8'h99, 1'b1, 1'b0);
    check("wr_depth", {3'b0, bus.depth}, 8'd2);
    check("wr_tos",   bus.tos, 8'h99);
    check("wr_nos",   bus.nos, 8'h40);
    do_op(ADV_1, 8'h77, 1'b1, 1'b0);
    check("advwr_depth", {3'b0, bus.depth}, 8'd3);
    check("advwr_tos",   bus.tos, 8'h77);
    check("advwr_nos",   bus.nos, 8'h99);

    // Push after pop reuses the popped slot only
    do_op(DES_1, 8'h00, 1'b0, 1'b0);
    push(8'h55);
    check("reuse_tos", bus.tos, 8'h55);
    check("reuse_nos", bus.nos, 8'h99);
    do_op(DES_2, 8'h00, 1'b0, 1'b0);
    check("reuse_base", bus.tos, 8'h40);

    // Fill to 16, overflow, then drain checking every level
    pulse_reset();
    for (int i = 0; i < 16; i++) push(8'(i));
    check("full_depth", {3'b0, bus.depth}, 8'd16);
    check("full_flag",  {7'b0, bus.full},  8'd1);
    check("full_tos",   bus.tos, 8'h0F);
    check("full_nos",   bus.nos, 8'h0E);
    push(8'hAA);
    check("ovf_depth", {3'b0, bus.depth}, 8'd16);
    check("ovf_tos",   bus.tos, 8'h0F);
    check("ovf_flag",  {7'b0, bus.ovf}, 8'd1);
    do_op(OP_HOLD, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", {7'b0, bus.ovf}, 8'd0);
    for (int i = 15; i >= 1; i--) begin
      do_op(DES_1, 8'h00, 1'b0, 1'b0);
      check("drain_tos", bus.tos, 8'(i - 1));
    end
    check("drain_nos", bus.nos, 8'h00);

    // Async reset between edges, then stale data must stay hidden
    pulse_reset();
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    do_op(DES_1, 8'h00, 1'b0, 1'b0);
    do_op(DES_1, 8'h00, 1'b0, 1'b0);
    do_op(DES_1, 8'h00, 1'b0, 1'b0);
    do_op(DES_1, 8'h00, 1'b0, 1'b0);
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_depth", {3'b0, bus.depth}, 8'd0);
    check("arst_tos",   bus.tos, 8'h00);
    check("arst_nos",   bus.nos, 8'h00);
    check("arst_ovf",   {7'b0, bus.ovf}, 8'd0);
    check("arst_unf",   {7'b0, bus.unf}, 8'd0);
    // An op presented while reset is held must be abandoned
    bus.op        = ADV_1;
    bus.push_data = 8'hCC;
    @(posedge clk);
    #1;
    check("arst_abandon", {3'b0, bus.depth}, 8'd0);
    bus.op = OP_HOLD;
    @(negedge clk);
    reset = 1'b1;
    push(8'h12);
    check("post_rst_tos",   bus.tos, 8'h12);
    check("post_rst_nos",   bus.nos, 8'h00);
    check("post_rst_depth", {3'b0, bus.depth}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_file.md
STACK_FILE -- requirements
Module: stack_file

Interface
REQ-001 SHALL provide ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-003 SHALL provide: op  in  2  stack operation, encodings from definitions package (ADV_1, DES_1, DES_2; any other value = hold).
REQ-004 SHALL provide: push_data  in  8  value written on ADV_1 or wr_top.
REQ-005 SHALL provide: wr_top  in  1  overwrite top entry with push_data; honoured only when op = hold.
REQ-006 SHALL provide: clr_err  in  1  synchronous clear of sticky error flags.
REQ-007 SHALL provide: tos  out  8  top-of-stack value; 0 when depth = 0.
REQ-008 SHALL provide: nos  out  8  next-of-stack value; 0 when depth < 2.
REQ-009 SHALL provide: depth  out  5  occupied entries, 0..16.
REQ-010 SHALL provide: empty  out  1  depth = 0;  full  out  1  depth = 16.
REQ-011 SHALL provide: ovf  out  1  sticky overflow;  unf  out  1  sticky underflow.
REQ-012 SHALL parameterise nothing: storage fixed at 16 x 8 bits, DEPTH_MAX = 16.

Function
REQ-013 SHALL hold storage mem[0..15] and a 5-bit depth register; entry k valid iff k < depth.
REQ-014 ADV_1, depth < 16: SHALL write push_data to mem[depth] and increment depth, both at the same edge.
REQ-015 ADV_1, depth = 16: SHALL leave mem and depth unchanged and set ovf.
REQ-016 DES_1, depth >= 1: SHALL decrement depth by 1; mem unchanged.
REQ-017 DES_1, depth = 0: SHALL leave depth unchanged and set unf.
REQ-018 DES_2, depth >= 2: SHALL decrement depth by 2; DES_2, depth < 2: SHALL leave depth unchanged (no partial pop) and set unf.
REQ-019 hold with wr_top = 1, depth >= 1: SHALL write push_data to mem[depth-1]; depth unchanged.
REQ-020 hold with wr_top = 1, depth = 0: SHALL perform no write and set unf.
REQ-021 wr_top SHALL be ignored (no write, no flag) whenever op != hold.
REQ-022 tos SHALL equal mem[depth-1] and nos mem[depth-2], decoded combinationally from registered state; updated values visible the cycle after the op edge (1-cycle latency).
REQ-023 tos/nos SHALL be forced to 0 for invalid positions per REQ-007/REQ-008, never exposing stale entries.
REQ-024 empty/full SHALL be combinational from depth, no extra latency.
REQ-025 ovf/unf SHALL remain set until clr_err or reset; clr_err clears both at the next edge.
REQ-026 clr_err coinciding with a new error event: the new event SHALL win (its flag set after the edge).
REQ-027 depth SHALL never leave 0..16; no arithmetic wrap permitted.
REQ-028 A push after pops SHALL overwrite the previously popped slot; no other slot modified.

Reset
REQ-029 reset = 0 SHALL asynchronously set depth = 0, ovf = 0, unf = 0; hence tos = 0, nos = 0, empty = 1, full = 0.
REQ-030 mem contents SHALL NOT be reset; invisible via REQ-023.
REQ-031 Reset asserted mid-sequence SHALL abandon any op in that cycle; first op after release SHALL be sampled at the first rising clk with reset = 1.

Verification
REQ-032 Push 0x11, 0x22, 0x33 -> depth 3, tos 0x33, nos 0x22, empty 0; then DES_2 -> depth 1, tos 0x11, nos 0.
REQ-033 Push 16 values 0x00..0x0F, then ADV_1 0xAA -> depth 16, full 1, tos 0x0F, ovf 1; clr_err -> ovf 0.
REQ-034 From reset, DES_1 -> depth 0, unf 1; push 0x05 then DES_2 -> depth 1, tos 0x05, unf 1 (no partial pop).
REQ-035 Push 0x40, 0x41; hold + wr_top 0x99 -> tos 0x99, nos 0x40; ADV_1 with wr_top 1, push_data 0x77 -> depth 3, tos 0x77, nos 0x99.
REQ-036 DES_1 at depth 0 with clr_err = 1 same cycle -> unf 1 after edge.
REQ-037 Push 3 values, drop reset between clk edges -> depth, tos, nos, ovf, unf 0 before next edge; push 0x12 -> tos 0x12, nos 0.
